// File: rtl/toggle_event_counter.sv
// toggle_event_counter
//   Counts level changes of an asynchronous toggle input. The input is
//   resynchronised through a SYNC_STAGES-deep flop chain. Each change of the
//   synchronised level is one event. Every event produces a one-cycle pulse.
//   An event is counted only when en is high. clr clears count and ovf, and
//   takes priority over an event in the same cycle.
//
// Parameters
//   WIDTH        event counter width in bits (default 8)
//   SYNC_STAGES  synchronizer depth, legal range 2..4 (default 2)
//
// Ports
//   clk     in   single clock, rising edge
//   rst     in   asynchronous active-high reset
//   tgl_in  in   asynchronous toggle level; each level change is one event
//   en      in   synchronous count enable
//   clr     in   synchronous clear of count and ovf
//   pulse   out  one-cycle registered strobe per detected event
//   count   out  number of counted events
//   ovf     out  sticky overflow flag
//
// Configuration
//   TOGGLE_CNT_SATURATE_EN  defined: count saturates at 2^WIDTH-1, and ovf
//                           sets on the event that reaches it.
//                           undefined: count wraps to 0, and ovf sets on the
//                           wrapping event.
module toggle_event_counter #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgl_in,
  input  logic             en,
  input  logic             clr,
  output logic             pulse,
  output logic [WIDTH-1:0] count,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync_out;
  logic                   prev;
  logic                   evt;
  logic [WIDTH-1:0]       count_nxt;
  logic                   ovf_nxt;

  // Synchronizer chain: the only reader of tgl_in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], tgl_in};
    end
  end

  assign sync_out = sync_ff[SYNC_STAGES-1];

  // Last synchronised level. en and clr have no influence here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= 1'b0;
    end else begin
      prev <= sync_out;
    end
  end

  assign evt = sync_out ^ prev;

  // Next count and overflow. clr wins over a simultaneous event.
  always_comb begin
    count_nxt = count;
    ovf_nxt   = ovf;
    if (clr) begin
      count_nxt = '0;
      ovf_nxt   = 1'b0;
    end else if (evt && en) begin
`ifdef TOGGLE_CNT_SATURATE_EN
      if (count == CNT_MAX) begin
        ovf_nxt = 1'b1;
      end else begin
        count_nxt = count + WIDTH'(1);
        if (count_nxt == CNT_MAX) begin
          ovf_nxt = 1'b1;
        end
      end
`else
      // Natural modulo-2^WIDTH wrap; flag the wrap itself.
      count_nxt = count + WIDTH'(1);
      if (count == CNT_MAX) begin
        ovf_nxt = 1'b1;
      end
`endif
    end
  end

  // Registered outputs. pulse fires on every event, whatever en and clr are.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse <= 1'b0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      pulse <= evt;
      count <= count_nxt;
      ovf   <= ovf_nxt;
    end
  end

endmodule
